// File: rtl/kpick_arb_pkg.sv
// -----------------------------------------------------------------------------
// kpick_arb_pkg
// Shared constants and width helpers for base2_kpick_arbiter.
//   KP_DW          FP16 data width
//   KP_LAT_ADD     extra picker latency stages on top of the 5-stage core
//   KP_PICK_LAT    picker valid_i -> valid_o latency
//   KP_K_W         width of the signed integer part k
//   kp_id_width    requester-ID width, never below 1 bit
//   kp_tag_width   width of a {valid, id} tag travelling beside the picker
//   kp_count_width width of the in-flight counter (holds 0..PICK_LAT+1)
// -----------------------------------------------------------------------------
package kpick_arb_pkg;

  localparam int KP_DW       = 16;
  localparam int KP_LAT_ADD  = 1;
  localparam int KP_PICK_LAT = 5 + KP_LAT_ADD;
  localparam int KP_K_W      = 8;

  function automatic int kp_id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int kp_tag_width(input int nreq);
    return 1 + kp_id_width(nreq);
  endfunction

  function automatic int kp_count_width(input int pick_lat);
    return $clog2(pick_lat + 2);
  endfunction

endpackage

// File: rtl/base2_kpick_arbiter_shift_reg.sv
// -----------------------------------------------------------------------------
// shift_reg
// Fixed-depth delay line with asynchronous active-low clear. Used to carry
// the {valid, id} tag alongside the picker so the tail lines up with the
// picker's output valid.
// Ports:
//   clk   clock
//   rstn  async active-low reset, clears every stage
//   d_i   value entering stage 0
//   q_o   value leaving the last stage (DEPTH cycles after entry)
// -----------------------------------------------------------------------------
module shift_reg #(
  parameter int DW    = 1,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] stage_q [DEPTH];
  logic [DW-1:0] stage_d [DEPTH];

  // Next value of each stage: stage 0 takes the input, others take their predecessor
  always_comb begin
    stage_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/base2_kpick_arbiter.sv
// -----------------------------------------------------------------------------
// base2_kpick_arbiter
// Shares one base2_k_picker pipeline between NREQ FP16 requesters.
// Round-robin grant with valid/ready handshake, a {valid,id} tag pipe that
// tracks each issue through the picker's fixed latency, and a registered
// one-hot response back to the originating lane.
//
// Optional feature: define KPICK_ARB_STATS_EN to add stat_grant_o, a
// per-lane saturating 16-bit handshake counter.
//
// Ports:
//   clk, rstn      clock, async active-low reset
//   req_valid_i    per-lane request valid
//   req_t_i        per-lane FP16 t, lane i = [i*DW +: DW]
//   req_ready_o    per-lane accept (one-hot or zero, combinational)
//   hold_i         1 = no new grants; in-flight work drains
//   pick_valid_o   to picker valid_i
//   pick_t_o       to picker t_i (holds when not issuing)
//   pick_valid_i   from picker valid_o
//   pick_k_i       from picker k_o (signed)
//   pick_kfp_i     from picker k_fp16_o
//   pick_f_i       from picker f_o
//   rsp_valid_o    one-hot result valid, no backpressure
//   rsp_id_o       requester ID of the current result
//   rsp_k_o        k (signed)
//   rsp_kfp_o      k in FP16
//   rsp_f_o        f = t - k
//   idle_o         nothing pending or in flight (registered)
//   err_o          sticky tag/valid misalignment flag
//   stat_grant_o   (KPICK_ARB_STATS_EN only) per-lane handshake counts
// -----------------------------------------------------------------------------
module base2_kpick_arbiter
  import kpick_arb_pkg::*;
#(
  parameter int DW       = KP_DW,
  parameter int NREQ     = 4,
  parameter int PICK_LAT = KP_PICK_LAT,
  parameter int IDW      = kp_id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*DW-1:0]   req_t_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic                 hold_i,
  output logic                 pick_valid_o,
  output logic [DW-1:0]        pick_t_o,
  input  logic                 pick_valid_i,
  input  logic [KP_K_W-1:0]    pick_k_i,
  input  logic [DW-1:0]        pick_kfp_i,
  input  logic [DW-1:0]        pick_f_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [KP_K_W-1:0]    rsp_k_o,
  output logic [DW-1:0]        rsp_kfp_o,
  output logic [DW-1:0]        rsp_f_o,
  output logic                 idle_o,
  output logic                 err_o
`ifdef KPICK_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   stat_grant_o
`endif
);

  localparam int TW = kp_tag_width(NREQ);
  localparam int CW = kp_count_width(PICK_LAT);

  // Registered state
  logic [IDW-1:0]    ptr_q,       ptr_d;
  logic              pick_valid_q, pick_valid_d;
  logic [IDW-1:0]    pick_id_q,   pick_id_d;
  logic [DW-1:0]     pick_t_q,    pick_t_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q,    rsp_id_d;
  logic [KP_K_W-1:0] rsp_k_q,     rsp_k_d;
  logic [DW-1:0]     rsp_kfp_q,   rsp_kfp_d;
  logic [DW-1:0]     rsp_f_q,     rsp_f_d;
  logic [CW-1:0]     count_q,     count_d;
  logic              idle_q,      idle_d;
  logic              err_q,       err_d;

  // Combinational grant results
  logic [NREQ-1:0]   grant_s;
  logic              gnt_any_s;
  logic [IDW-1:0]    gnt_id_s;
  logic [DW-1:0]     gnt_t_s;

  // Tag pipe
  logic [TW-1:0]     tag_in_s;
  logic [TW-1:0]     tag_tail_s;
  logic              tail_valid_s;
  logic [IDW-1:0]    tail_id_s;
  logic              rsp_ok_s;

  // Round-robin priority scan starting at ptr; grant suppressed while holding
  always_comb begin
    int idx;
    idx       = 0;
    grant_s   = '0;
    gnt_any_s = 1'b0;
    gnt_id_s  = '0;
    gnt_t_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ((int'(ptr_q) + k) >= NREQ) ? (int'(ptr_q) + k - NREQ) : (int'(ptr_q) + k);
      if (!gnt_any_s && !hold_i && req_valid_i[idx]) begin
        gnt_any_s     = 1'b1;
        grant_s[idx]  = 1'b1;
        gnt_id_s      = idx[IDW-1:0];
        gnt_t_s       = req_t_i[idx*DW +: DW];
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  assign req_ready_o = grant_s;

  // Tag entering the pipe mirrors what is being presented to the picker this cycle
  assign tag_in_s     = {pick_valid_q, pick_id_q};
  assign tail_valid_s = tag_tail_s[TW-1];
  assign tail_id_s    = tag_tail_s[IDW-1:0];
  assign rsp_ok_s     = tail_valid_s & pick_valid_i;

  shift_reg #(
    .DW    (TW),
    .DEPTH (PICK_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (tag_in_s),
    .q_o  (tag_tail_s)
  );

  // Next-state logic for issue, response, counter, idle and error
  always_comb begin
    // Issue side: a handshake moves the pointer past the winner and launches its t
    if (gnt_any_s) begin
      ptr_d        = (gnt_id_s == IDW'(NREQ-1)) ? '0 : (gnt_id_s + IDW'(1));
      pick_valid_d = 1'b1;
      pick_id_d    = gnt_id_s;
      pick_t_d     = gnt_t_s;
    end else begin
      ptr_d        = ptr_q;
      pick_valid_d = 1'b0;
      pick_id_d    = pick_id_q;
      pick_t_d     = pick_t_q;
    end

    // Response side: only a matched tag and picker valid produce a result
    if (rsp_ok_s) begin
      rsp_valid_d = {{(NREQ-1){1'b0}}, 1'b1} << tail_id_s;
      rsp_id_d    = tail_id_s;
      rsp_k_d     = pick_k_i;
      rsp_kfp_d   = pick_kfp_i;
      rsp_f_d     = pick_f_i;
    end else begin
      rsp_valid_d = '0;
      rsp_id_d    = rsp_id_q;
      rsp_k_d     = rsp_k_q;
      rsp_kfp_d   = rsp_kfp_q;
      rsp_f_d     = rsp_f_q;
    end

    // In-flight count counts from handshake until the tag leaves the pipe,
    // so a phantom-free retire still happens even when the result is dropped
    case ({gnt_any_s, tail_valid_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    idle_d = (count_q == '0) && !pick_valid_q;
    err_d  = err_q | (tail_valid_s ^ pick_valid_i);
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q        <= '0;
      pick_valid_q <= 1'b0;
      pick_id_q    <= '0;
      pick_t_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_id_q     <= '0;
      rsp_k_q      <= '0;
      rsp_kfp_q    <= '0;
      rsp_f_q      <= '0;
      count_q      <= '0;
      idle_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      pick_valid_q <= pick_valid_d;
      pick_id_q    <= pick_id_d;
      pick_t_q     <= pick_t_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_k_q      <= rsp_k_d;
      rsp_kfp_q    <= rsp_kfp_d;
      rsp_f_q      <= rsp_f_d;
      count_q      <= count_d;
      idle_q       <= idle_d;
      err_q        <= err_d;
    end
  end

  assign pick_valid_o = pick_valid_q;
  assign pick_t_o     = pick_t_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_k_o      = rsp_k_q;
  assign rsp_kfp_o    = rsp_kfp_q;
  assign rsp_f_o      = rsp_f_q;
  assign idle_o       = idle_q;
  assign err_o        = err_q;

`ifdef KPICK_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_q, stat_d;

  // Per-lane saturating handshake counters
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i] && (stat_q[i*16 +: 16] != 16'hFFFF)) begin
        stat_d[i*16 +: 16] = stat_q[i*16 +: 16] + 16'd1;
      end else begin
        stat_d[i*16 +: 16] = stat_q[i*16 +: 16];
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_grant_o = stat_q;
`endif

endmodule

// File: tb/tb_base2_kpick_arbiter.sv
// -----------------------------------------------------------------------------
// tb_base2_kpick_arbiter
// Directed bench for base2_kpick_arbiter with a 6-cycle picker model whose
// results come from a small table of hand-computed FP16 values.
// -----------------------------------------------------------------------------
module tb_base2_kpick_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [63:0] req_t;
  logic [3:0]  req_ready;
  logic        hold;
  logic        pick_valid;
  logic [15:0] pick_t;
  logic        pick_valid_in;
  logic [7:0]  pick_k;
  logic [15:0] pick_kfp;
  logic [15:0] pick_f;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_k;
  logic [15:0] rsp_kfp;
  logic [15:0] rsp_f;
  logic        idle;
  logic        err;
  logic        force_pv;
`ifdef KPICK_ARB_STATS_EN
  logic [63:0] stat_grant;
`endif

  int total;
  int bad;

  base2_kpick_arbiter dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid_i  (req_valid),
    .req_t_i      (req_t),
    .req_ready_o  (req_ready),
    .hold_i       (hold),
    .pick_valid_o (pick_valid),
    .pick_t_o     (pick_t),
    .pick_valid_i (pick_valid_in),
    .pick_k_i     (pick_k),
    .pick_kfp_i   (pick_kfp),
    .pick_f_i     (pick_f),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_k_o      (rsp_k),
    .rsp_kfp_o    (rsp_kfp),
    .rsp_f_o      (rsp_f),
    .idle_o       (idle),
    .err_o        (err)
`ifdef KPICK_ARB_STATS_EN
    ,
    .stat_grant_o (stat_grant)
`endif
  );

  always #5 clk = ~clk;

  // Picker stimulus table: {k, k_fp16, f}
  function automatic logic [39:0] pick_lut(input logic [15:0] t);
    case (t)
      16'h3C00: return {8'h01, 16'h3C00, 16'h0000};
      16'h4200: return {8'h03, 16'h4200, 16'h0000};
      16'h4100: return {8'h02, 16'h4000, 16'h3800};
      16'h4400: return {8'h04, 16'h4400, 16'h0000};
      16'hBE00: return {8'hFE, 16'hC000, 16'h3800};
      default:  return 40'h0;
    endcase
  endfunction

  logic [5:0]  pv_pipe;
  logic [15:0] pt_pipe [6];
  logic [39:0] lut_out;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv_pipe <= 6'b0;
      for (int i = 0; i < 6; i++) pt_pipe[i] <= 16'h0;
    end else begin
      pv_pipe    <= {pv_pipe[4:0], pick_valid};
      pt_pipe[0] <= pick_t;
      for (int i = 1; i < 6; i++) pt_pipe[i] <= pt_pipe[i-1];
    end
  end

  assign pick_valid_in = pv_pipe[5] | force_pv;
  assign lut_out       = pick_lut(pt_pipe[5]);
  assign pick_k        = lut_out[39:32];
  assign pick_kfp      = lut_out[31:16];
  assign pick_f        = lut_out[15:0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = 4'b0;
    hold      = 1'b0;
    force_pv  = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pick_valid"}, {63'd0, pick_valid}, 64'd0);
    chk({tag, "_pick_t"},     {48'd0, pick_t},     64'd0);
    chk({tag, "_rsp_valid"},  {60'd0, rsp_valid},  64'd0);
    chk({tag, "_rsp_id"},     {62'd0, rsp_id},     64'd0);
    chk({tag, "_rsp_k"},      {56'd0, rsp_k},      64'd0);
    chk({tag, "_rsp_kfp"},    {48'd0, rsp_kfp},    64'd0);
    chk({tag, "_rsp_f"},      {48'd0, rsp_f},      64'd0);
    chk({tag, "_idle"},       {63'd0, idle},       64'd1);
    chk({tag, "_err"},        {63'd0, err},        64'd0);
  endtask

  logic [7:0]  exp_k   [4];
  logic [15:0] exp_kfp [4];
  logic [15:0] exp_f   [4];

  initial begin
    exp_k   = '{8'h01, 8'h03, 8'h02, 8'h04};
    exp_kfp = '{16'h3C00, 16'h4200, 16'h4000, 16'h4400};
    exp_f   = '{16'h0000, 16'h0000, 16'h3800, 16'h0000};
    total = 0;
    bad   = 0;
    clk = 1'b0; rstn = 1'b1; req_valid = 4'b0; req_t = 64'h0; hold = 1'b0; force_pv = 1'b0;

    // Reset state
    #2 rstn = 1'b0;
    tick();
    chk_reset_vals("rst");
    req_valid = 4'b1111;
    #1 chk("rst_ready_ptr0", {60'd0, req_ready}, 64'h1);
    req_valid = 4'b0;
    rstn = 1'b1;
    tick();

    // Test 1: lane 2 alone, t=2.5
    req_t = {16'h4400, 16'h4100, 16'h4200, 16'h3C00};
    req_valid = 4'b0100;
    #1 chk("t1_ready", {60'd0, req_ready}, 64'h4);
    tick();                                   // N+1
    req_valid = 4'b0;
    chk("t1_pick_valid", {63'd0, pick_valid}, 64'd1);
    chk("t1_pick_t", {48'd0, pick_t}, 64'h4100);
    tick();                                   // N+2
    chk("t1_pick_valid_low", {63'd0, pick_valid}, 64'd0);
    chk("t1_pick_t_hold", {48'd0, pick_t}, 64'h4100);
    repeat (5) tick();                        // N+7
    chk("t1_rsp_early", {60'd0, rsp_valid}, 64'd0);
    tick();                                   // N+8
    chk("t1_rsp_valid", {60'd0, rsp_valid}, 64'h4);
    chk("t1_rsp_id", {62'd0, rsp_id}, 64'd2);
    chk("t1_rsp_k", {56'd0, rsp_k}, 64'h02);
    chk("t1_rsp_kfp", {48'd0, rsp_kfp}, 64'h4000);
    chk("t1_rsp_f", {48'd0, rsp_f}, 64'h3800);
    chk("t1_idle_busy", {63'd0, idle}, 64'd0);
    tick();                                   // N+9
    chk("t1_rsp_done", {60'd0, rsp_valid}, 64'd0);
    chk("t1_rsp_k_hold", {56'd0, rsp_k}, 64'h02);
    chk("t1_idle", {63'd0, idle}, 64'd1);

    // Test 2: all lanes continuously from reset
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("t2_ready_%0d", i), {60'd0, req_ready}, 64'd1 << (i % 4));
      tick();
    end
    req_valid = 4'b0;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("t2_rsp_valid_%0d", j), {60'd0, rsp_valid}, 64'd1 << (j % 4));
      chk($sformatf("t2_rsp_id_%0d", j), {62'd0, rsp_id}, 64'(j % 4));
      chk($sformatf("t2_rsp_k_%0d", j), {56'd0, rsp_k}, {56'd0, exp_k[j % 4]});
      chk($sformatf("t2_rsp_kfp_%0d", j), {48'd0, rsp_kfp}, {48'd0, exp_kfp[j % 4]});
      chk($sformatf("t2_rsp_f_%0d", j), {48'd0, rsp_f}, {48'd0, exp_f[j % 4]});
      tick();
    end
    chk("t2_rsp_end", {60'd0, rsp_valid}, 64'd0);
    chk("t2_err", {63'd0, err}, 64'd0);
`ifdef KPICK_ARB_STATS_EN
    chk("t2_stat", stat_grant, {16'd2, 16'd2, 16'd2, 16'd2});
`endif

    // Test 3: lanes 1 and 3, pointer parked at 2, t=-1.5
    do_reset();
    req_t = {16'hBE00, 16'h4100, 16'hBE00, 16'h3C00};
    req_valid = 4'b0010;
    #1 chk("t3_pre_ready", {60'd0, req_ready}, 64'h2);
    tick();
    req_valid = 4'b0;
    repeat (10) tick();
    req_valid = 4'b1010;
    #1 chk("t3_ready_a", {60'd0, req_ready}, 64'h8);
    tick();
    #1 chk("t3_ready_b", {60'd0, req_ready}, 64'h2);
    tick();
    #1 chk("t3_ready_c", {60'd0, req_ready}, 64'h8);
    tick();                                   // M+3
    req_valid = 4'b0;
    repeat (5) tick();                        // M+8
    chk("t3_rsp_valid_a", {60'd0, rsp_valid}, 64'h8);
    chk("t3_rsp_id_a", {62'd0, rsp_id}, 64'd3);
    chk("t3_rsp_k_a", {56'd0, rsp_k}, 64'hFE);
    chk("t3_rsp_kfp_a", {48'd0, rsp_kfp}, 64'hC000);
    chk("t3_rsp_f_a", {48'd0, rsp_f}, 64'h3800);
    tick();
    chk("t3_rsp_valid_b", {60'd0, rsp_valid}, 64'h2);
    chk("t3_rsp_id_b", {62'd0, rsp_id}, 64'd1);
    tick();
    chk("t3_rsp_valid_c", {60'd0, rsp_valid}, 64'h8);
    chk("t3_rsp_id_c", {62'd0, rsp_id}, 64'd3);
    tick();
    chk("t3_rsp_end", {60'd0, rsp_valid}, 64'd0);

    // Test 4: hold with three in flight
    req_t = {16'h4400, 16'h4100, 16'h4200, 16'h3C00};
    req_valid = 4'b1111;
    #1 chk("t4_ready_0", {60'd0, req_ready}, 64'h1);
    tick();
    #1 chk("t4_ready_1", {60'd0, req_ready}, 64'h2);
    tick();
    #1 chk("t4_ready_2", {60'd0, req_ready}, 64'h4);
    tick();                                   // H+3
    hold = 1'b1;
    #1 chk("t4_ready_hold", {60'd0, req_ready}, 64'd0);
    chk("t4_pick_valid_last", {63'd0, pick_valid}, 64'd1);
    tick();                                   // H+4
    chk("t4_pick_valid_hold", {63'd0, pick_valid}, 64'd0);
    chk("t4_ready_hold2", {60'd0, req_ready}, 64'd0);
    repeat (4) tick();                        // H+8
    chk("t4_rsp_0", {60'd0, rsp_valid}, 64'h1);
    tick();                                   // H+9
    chk("t4_rsp_1", {60'd0, rsp_valid}, 64'h2);
    chk("t4_idle_busy_a", {63'd0, idle}, 64'd0);
    tick();                                   // H+10
    chk("t4_rsp_2", {60'd0, rsp_valid}, 64'h4);
    chk("t4_rsp_k_2", {56'd0, rsp_k}, 64'h02);
    chk("t4_idle_busy_b", {63'd0, idle}, 64'd0);
    chk("t4_ready_hold3", {60'd0, req_ready}, 64'd0);
    tick();                                   // H+11
    chk("t4_idle", {63'd0, idle}, 64'd1);
    chk("t4_rsp_end", {60'd0, rsp_valid}, 64'd0);

    // Test 5: phantom picker valid with empty tag pipe
    chk("t5_err_before", {63'd0, err}, 64'd0);
    force_pv = 1'b1;
    tick();
    force_pv = 1'b0;
    chk("t5_err_set", {63'd0, err}, 64'd1);
    chk("t5_no_rsp", {60'd0, rsp_valid}, 64'd0);
    repeat (3) tick();
    chk("t5_err_sticky", {63'd0, err}, 64'd1);
    chk("t5_no_rsp_later", {60'd0, rsp_valid}, 64'd0);
    chk("t5_idle", {63'd0, idle}, 64'd1);

    // Test 6: reset with four in flight (pointer sits at lane 3)
    hold = 1'b0;
    #1 chk("t6_ready_a", {60'd0, req_ready}, 64'h8);
    tick();
    #1 chk("t6_ready_b", {60'd0, req_ready}, 64'h1);
    tick();
    #1 chk("t6_ready_c", {60'd0, req_ready}, 64'h2);
    tick();
    #1 chk("t6_ready_d", {60'd0, req_ready}, 64'h4);
    tick();
    rstn = 1'b0;
    #1 chk_reset_vals("t6_rst");
    chk("t6_rst_ready_ptr0", {60'd0, req_ready}, 64'h1);
`ifdef KPICK_ARB_STATS_EN
    chk("t6_stat", stat_grant, 64'd0);
`endif
    req_valid = 4'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("t6_no_stale_%0d", i), {60'd0, rsp_valid}, 64'd0);
    end
    chk("t6_err", {63'd0, err}, 64'd0);
    chk("t6_idle", {63'd0, idle}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
